// File: rtl/color_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : color_pkg
//  Description : Shared pixel colour type (RGB565, 16 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
package color_pkg;

   typedef logic [15:0] color16_t;

endpackage : color_pkg
`default_nettype wire

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Framebuffer geometry defaults, address/write-entry types and
//                the writer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;
   import color_pkg::*;

   localparam int FB_WIDTH_DEFAULT  = 160;
   localparam int FB_HEIGHT_DEFAULT = 120;
   localparam int FB_ADDR_WIDTH     = $clog2(FB_WIDTH_DEFAULT * FB_HEIGHT_DEFAULT);

   typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

   // One framebuffer write for the default geometry
   typedef struct packed {
      fb_addr_t addr;
      color16_t color;
   } fb_wr_t;

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_CLEAR = 1'b1
   } fb_state_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head entry is
//                read straight from the storage registers, so it is visible
//                the cycle after it is written. Push when full and pop when
//                empty are ignored. Full/empty derive from the registered count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rd_ptr];

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping (pointers wrap since DEPTH is 2^n)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_writer
//  Description : Buffers depth-passed pixels, converts (x,y) to a linear
//                framebuffer address and drives a ready/valid write port.
//                Also performs full-screen clears between frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_writer
   import color_pkg::*;
   import fb_pkg::*;
#(
   parameter  int FB_WIDTH   = FB_WIDTH_DEFAULT,
   parameter  int FB_HEIGHT  = FB_HEIGHT_DEFAULT,
   parameter  int FIFO_DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  color16_t              in_color,
   input  logic [15:0]           in_x,
   input  logic [15:0]           in_y,
   input  logic                  clear_start,
   input  color16_t              clear_color,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output color16_t              mem_data,
   output logic                  busy,
   output logic                  overflow
);

   localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

   // Same layout as fb_wr_t, sized for this instance's geometry
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      color16_t              color;
   } wr_t;

   fb_state_t             r_state;
   logic                  r_clear_pending;
   logic [ADDR_WIDTH-1:0] r_clear_ctr;
   color16_t              r_clr_color;

   logic                  w_in_range;
   logic [ADDR_WIDTH-1:0] w_pix_addr;
   wr_t                   w_fifo_wdata;
   wr_t                   w_fifo_rdata;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [FIFO_CW-1:0]    w_fifo_count;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_pop;
   logic                  w_out_free;
   logic                  w_clear_accept;
   logic                  w_clear_go;
   logic                  w_clear_last;

   // Range check first so the narrowed multiply operands never truncate
   assign w_in_range   = (in_x < 16'(FB_WIDTH)) && (in_y < 16'(FB_HEIGHT));
   assign w_pix_addr   = ADDR_WIDTH'(in_y) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(in_x);
   assign w_fifo_wdata = {w_pix_addr, in_color};

   // Full is the registered count only; a pop in the same cycle frees nothing
   assign w_push = in_valid && w_in_range && !w_fifo_full;
   assign w_drop = in_valid && w_in_range && w_fifo_full;

   // Output register can take a new entry when empty or handshaking now
   assign w_out_free = !mem_valid || mem_ready;
   assign w_pop      = (r_state == S_RUN) && w_out_free && !w_fifo_empty;

   assign w_clear_accept = clear_start && !r_clear_pending && (r_state != S_CLEAR);
   assign w_clear_go     = (r_state == S_RUN) && r_clear_pending && w_fifo_empty && w_out_free;
   assign w_clear_last   = (r_clear_ctr == ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1));

   assign busy = r_clear_pending || (r_state == S_CLEAR) || (w_fifo_count != '0) || mem_valid;

   sync_fifo #(
      .WIDTH (ADDR_WIDTH + 16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // Control FSM: pixel drain, clear sequencing, output register and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_RUN;
         r_clear_pending <= 1'b0;
         r_clear_ctr     <= '0;
         r_clr_color     <= '0;
         mem_valid       <= 1'b0;
         mem_addr        <= '0;
         mem_data        <= '0;
         overflow        <= 1'b0;
      end else begin
         if (w_clear_accept) begin
            r_clear_pending <= 1'b1;
            r_clr_color     <= clear_color;
         end

         // A drop in the same cycle as a clear request leaves the flag set
         if (w_drop) begin
            overflow <= 1'b1;
         end else if (w_clear_accept) begin
            overflow <= 1'b0;
         end

         case (r_state)
            S_RUN: begin
               if (w_clear_go) begin
                  r_state     <= S_CLEAR;
                  r_clear_ctr <= '0;
                  mem_valid   <= 1'b1;
                  mem_addr    <= '0;
                  mem_data    <= r_clr_color;
               end else if (w_pop) begin
                  mem_valid <= 1'b1;
                  mem_addr  <= w_fifo_rdata.addr;
                  mem_data  <= w_fifo_rdata.color;
               end else if (mem_ready) begin
                  mem_valid <= 1'b0;
               end
            end
            S_CLEAR: begin
               // mem_valid stays high throughout; address follows the counter
               if (mem_ready) begin
                  if (w_clear_last) begin
                     r_state         <= S_RUN;
                     r_clear_pending <= 1'b0;
                     mem_valid       <= 1'b0;
                  end else begin
                     r_clear_ctr <= r_clear_ctr + ADDR_WIDTH'(1);
                     mem_addr    <= r_clear_ctr + ADDR_WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

endmodule : framebuffer_writer
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_framebuffer_writer
//  Description : Self-checking bench for framebuffer_writer. Expected memory
//                writes are kept as an ordered queue built from the pixels and
//                clears the bench issues; a negedge monitor checks every
//                handshake and the hold rule while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_writer;
   import color_pkg::*;

   localparam int W    = 160;
   localparam int H    = 120;
   localparam int D    = 16;
   localparam int AW   = 15;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   color16_t      in_color = '0;
   logic [15:0]   in_x = '0;
   logic [15:0]   in_y = '0;
   logic          clear_start = 1'b0;
   color16_t      clear_color = '0;
   logic          mem_valid;
   logic          mem_ready = 1'b0;
   logic [AW-1:0] mem_addr;
   color16_t      mem_data;
   logic          busy;
   logic          overflow;

   typedef struct {
      int addr;
      int color;
   } wr_t;

   wr_t           exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            n_writes = 0;
   bit            prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   color16_t      prev_data = '0;

   framebuffer_writer #(
      .FB_WIDTH   (W),
      .FB_HEIGHT  (H),
      .FIFO_DEPTH (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_color    (in_color),
      .in_x        (in_x),
      .in_y        (in_y),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Write monitor: every handshake must match the head of the expected queue
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", {31'd0, mem_valid}, 32'd1);
            check("hold_addr", {17'd0, mem_addr}, {17'd0, prev_addr});
            check("hold_data", {16'd0, mem_data}, {16'd0, prev_data});
         end
         if (mem_valid && mem_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", mem_addr, mem_data);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               check("wr_addr", {17'd0, mem_addr}, w.addr);
               check("wr_data", {16'd0, mem_data}, w.color);
            end
         end
         prev_stall = mem_valid && !mem_ready;
         prev_addr  = mem_addr;
         prev_data  = mem_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pixel for one cycle; the model records it if in range and accepted
   task automatic send(input int x, input int y, input int c, input bit accept);
      in_valid = 1'b1;
      in_x     = 16'(x);
      in_y     = 16'(y);
      in_color = 16'(c);
      if (accept && x < W && y < H) begin
         wr_t w;
         w.addr  = y * W + x;
         w.color = c & 16'hFFFF;
         exp_q.push_back(w);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic model_clear(input int c);
      for (int a = 0; a < NPIX; a++) begin
         wr_t w;
         w.addr  = a;
         w.color = c;
         exp_q.push_back(w);
      end
   endtask

   task automatic pulse_clear(input int c);
      clear_start = 1'b1;
      clear_color = 16'(c);
      tick();
      clear_start = 1'b0;
   endtask

   task automatic wait_drain(input int bound, input string name);
      int i = 0;
      while (exp_q.size() != 0 && i < bound) begin
         tick();
         i++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic wait_writes(input int target, input int bound, input string name);
      int i = 0;
      while (n_writes < target && i < bound) begin
         tick();
         i++;
      end
      check(name, {31'd0, (n_writes >= target)}, 32'd1);
   endtask

   task automatic mid_cycle_reset(input string name);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check({name, "_valid"}, {31'd0, mem_valid}, 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int w0;
      int sent;
      int guard;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_addr", {17'd0, mem_addr}, 32'd0);
      check("rst_data", {16'd0, mem_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      tick();

      // Single pixel: visible two cycles after it is presented
      mem_ready = 1'b1;
      w0 = n_writes;
      send(3, 2, 16'hF800, 1'b1);
      check("lat_n1_valid", {31'd0, mem_valid}, 32'd0);
      tick();
      check("lat_n2_valid", {31'd0, mem_valid}, 32'd1);
      check("lat_addr", {17'd0, mem_addr}, 32'd323);
      check("lat_data", {16'd0, mem_data}, 32'hF800);
      repeat (5) tick();
      check("single_write_count", n_writes - w0, 1);
      check("single_idle_busy", {31'd0, busy}, 32'd0);

      // 20 back-to-back pixels with memory stalled: pixel 0 reaches the
      // output register before the stall bites, then 16 more fill the FIFO
      mem_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send(i, 5, 16'h1000 + i, (i <= D));
      end
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_head_addr", {17'd0, mem_addr}, 32'd800);
      check("ovf_busy", {31'd0, busy}, 32'd1);
      mem_ready = 1'b1;
      wait_drain(200, "ovf_drain");
      repeat (3) tick();
      check("ovf_idle_valid", {31'd0, mem_valid}, 32'd0);

      // Random streaming with random backpressure; kept below FIFO capacity
      sent  = 0;
      guard = 0;
      while (sent < 100 && guard < 5000) begin
         guard++;
         mem_ready = 1'($urandom_range(0, 1));
         if (exp_q.size() < D - 1 && $urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 9) == 0) begin
               send(W + $urandom_range(0, 40), $urandom_range(0, H + 20), $urandom, 1'b1);
            end else begin
               send($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 16'hFFFF), 1'b1);
               sent++;
            end
         end else begin
            tick();
         end
      end
      check("rand_sent", sent, 100);
      mem_ready = 1'b1;
      wait_drain(500, "rand_drain");
      check("rand_overflow_sticky", {31'd0, overflow}, 32'd1);

      // Clear with 3 pixels queued: pixels first, then the full fill
      mem_ready = 1'b0;
      send(10, 0, 16'hAAAA, 1'b1);
      send(11, 0, 16'hBBBB, 1'b1);
      send(12, 0, 16'hCCCC, 1'b1);
      pulse_clear(16'h001F);
      model_clear(16'h001F);
      check("clr1_overflow_cleared", {31'd0, overflow}, 32'd0);
      check("clr1_busy", {31'd0, busy}, 32'd1);
      repeat (3) tick();
      mem_ready = 1'b1;
      wait_drain(NPIX + 200, "clr1_drain");
      check("clr1_busy_after", {31'd0, busy}, 32'd0);
      check("clr1_valid_after", {31'd0, mem_valid}, 32'd0);

      // Pixels arriving mid-clear land after it; a second request is ignored
      w0 = n_writes;
      pulse_clear(16'h07E0);
      model_clear(16'h07E0);
      wait_writes(w0 + 1, 20, "clr2_started");
      for (int i = 0; i < 5; i++) begin
         send($urandom_range(0, W - 1), $urandom_range(0, H - 1), 16'h4000 + i, 1'b1);
      end
      pulse_clear(16'hFFFF);
      wait_drain(NPIX + 200, "clr2_drain");
      check("clr2_busy_after", {31'd0, busy}, 32'd0);
      repeat (5) tick();
      check("clr2_no_extra", {31'd0, mem_valid}, 32'd0);

      // Out-of-range pixels are silently discarded
      w0 = n_writes;
      send(160, 0, 16'h1234, 1'b1);
      send(0, 120, 16'h5678, 1'b1);
      repeat (4) tick();
      check("oor_overflow", {31'd0, overflow}, 32'd0);
      check("oor_no_write", n_writes - w0, 0);
      check("oor_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a clear, then a fresh clear
      w0 = n_writes;
      pulse_clear(16'hABCD);
      model_clear(16'hABCD);
      wait_writes(w0 + 50, 200, "clr3_progress");
      mid_cycle_reset("clr3_rst");
      check("clr3_post_busy", {31'd0, busy}, 32'd0);
      pulse_clear(16'h5555);
      model_clear(16'h5555);
      tick();
      check("clr4_first_valid", {31'd0, mem_valid}, 32'd1);
      check("clr4_first_addr", {17'd0, mem_addr}, 32'd0);
      check("clr4_first_data", {16'd0, mem_data}, 32'h5555);
      w0 = n_writes;
      wait_writes(w0 + 100, 300, "clr4_progress");
      mid_cycle_reset("clr4_rst");
      repeat (3) tick();
      check("final_busy", {31'd0, busy}, 32'd0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_framebuffer_writer
`default_nettype wire
